// File: rtl/gte_ucode_sequencer_if.sv
// Command, ROM and compute-path bundle of the GTE microcode sequencer.
// master drives commands and ROM data; slave is the sequencer itself.
interface gte_ucode_sequencer_if #(
    parameter int CTRL_W = 64,
    parameter int ADDR_W = 9
);
    logic              i_start;
    logic [ADDR_W-1:0] i_entryAddr;
    logic              i_abort;
    logic              i_hold;
    logic [ADDR_W-1:0] o_romAddr;
    logic              o_romEn;
    logic [CTRL_W+2:0] i_romData;
    logic [CTRL_W-1:0] o_ctrl;
    logic              o_ctrlValid;
    logic              o_busy;
    logic              o_done;
    logic [5:0]        o_step;
    logic              o_err;

    modport master (
        output i_start, i_entryAddr, i_abort, i_hold, i_romData,
        input  o_romAddr, o_romEn, o_ctrl, o_ctrlValid,
        input  o_busy, o_done, o_step, o_err
    );

    modport slave (
        input  i_start, i_entryAddr, i_abort, i_hold, i_romData,
        output o_romAddr, o_romEn, o_ctrl, o_ctrlValid,
        output o_busy, o_done, o_step, o_err
    );
endinterface

// File: rtl/gte_ucode_sequencer.sv
// Microcode sequencer for the GTE: fetches control words from a
// 1-cycle synchronous ROM and issues them, with wait stalls and hold.
module gte_ucode_sequencer #(
    parameter int CTRL_W = 64,
    parameter int ADDR_W = 9
) (
    input logic                 i_clk,
    input logic                 i_nRst,
    gte_ucode_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, WAIT} state_t;

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [5:0] STEP_MAX = 6'd63;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] romAddrQ;
    logic [ADDR_W-1:0] pcNext;
    logic              romEnQ;
    logic              doneQ;
    logic              errQ;
    logic [1:0]        cnt;
    logic [5:0]        step;

    logic              last;
    logic [1:0]        wt;
    logic              busy;
    logic              abort;
    logic              run;
    logic              valid;
    logic              stop;

    assign last   = bus.i_romData[CTRL_W+2];
    assign wt     = bus.i_romData[CTRL_W+1:CTRL_W];
    assign pcNext = pc + ONE;
    assign busy   = (state != IDLE);
    assign abort  = bus.i_abort && busy;
    assign run    = !abort && !bus.i_hold;
    assign valid  = (state == EXEC) && run;
    // The 64th step without LAST is forced to end the instruction.
    assign stop   = last || (step == STEP_MAX);

    assign bus.o_ctrl      = valid ? bus.i_romData[CTRL_W-1:0] : '0;
    assign bus.o_ctrlValid = valid;
    // ROM must not advance while stalled, else the held word is lost.
    assign bus.o_romEn     = romEnQ && run;
    assign bus.o_romAddr   = romAddrQ;
    assign bus.o_busy      = busy;
    assign bus.o_done      = doneQ && !bus.i_hold;
    assign bus.o_step      = step;
    assign bus.o_err       = errQ;

    always_ff @(posedge i_clk) begin
        if (!i_nRst) begin
            state    <= IDLE;
            pc       <= '0;
            romAddrQ <= '0;
            romEnQ   <= 1'b0;
            doneQ    <= 1'b0;
            errQ     <= 1'b0;
            cnt      <= 2'd0;
            step     <= 6'd0;
        end else if (abort) begin
            state  <= IDLE;
            romEnQ <= 1'b0;
            doneQ  <= 1'b0;
        end else if (!bus.i_hold) begin
            doneQ <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.i_start && !bus.i_abort) begin
                        pc       <= bus.i_entryAddr;
                        romAddrQ <= bus.i_entryAddr;
                        romEnQ   <= 1'b1;
                        step     <= 6'd0;
                        errQ     <= 1'b0;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    pc       <= pcNext;
                    romAddrQ <= pcNext;
                    romEnQ   <= 1'b1;
                    state    <= EXEC;
                end
                EXEC: begin
                    if (step != STEP_MAX) begin
                        step <= step + 6'd1;
                    end
                    if (stop) begin
                        state  <= IDLE;
                        romEnQ <= 1'b0;
                        doneQ  <= 1'b1;
                        if (!last) begin
                            errQ <= 1'b1;
                        end
                    end else if (wt != 2'd0) begin
                        cnt    <= wt;
                        romEnQ <= 1'b0;
                        state  <= WAIT;
                    end else begin
                        pc       <= pcNext;
                        romAddrQ <= pcNext;
                        romEnQ   <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 2'd1;
                    if (cnt == 2'd1) begin
                        pc       <= pcNext;
                        romAddrQ <= pcNext;
                        romEnQ   <= 1'b1;
                        state    <= EXEC;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gte_ucode_sequencer.sv
// Bench for gte_ucode_sequencer: ROM model plus a program-walk
// reference giving expected payloads, completion cycle, step and err.
module tb_gte_ucode_sequencer;
    localparam int CW = 64;
    localparam int AW = 9;
    localparam int DEPTH = 512;

    logic clk = 1'b0;
    logic nRst;
    logic [CW+2:0] romQ = '0;
    logic [CW+2:0] mem [DEPTH];

    int checks = 0;
    int errors = 0;

    logic [CW-1:0] expQ [$];
    int expDoneRel;
    int expStep;
    int expErr;

    gte_ucode_sequencer_if #(.CTRL_W(CW), .ADDR_W(AW)) bus ();

    gte_ucode_sequencer #(.CTRL_W(CW), .ADDR_W(AW)) dut (
        .i_clk  (clk),
        .i_nRst (nRst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    assign bus.i_romData = romQ;

    always @(posedge clk) begin
        if (bus.o_romEn) romQ <= mem[bus.o_romAddr];
    end

    task automatic chk(input string tag, input logic [CW+2:0] obs,
                       input logic [CW+2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadProg(input int e, input int n,
                            input bit withLast, input bit useWaits);
        logic [CW-1:0] p;
        logic [1:0] w;
        logic l;
        for (int i = 0; i < n; i++) begin
            p = {$urandom, $urandom};
            w = useWaits ? 2'($urandom_range(0, 3)) : 2'd0;
            l = withLast && (i == n - 1);
            mem[(e + i) % DEPTH] = {l, w, p};
        end
    endtask

    // Walk the program as the ISA describes it: one step per word,
    // WAIT adds stall cycles, LAST or the 64th step ends it.
    task automatic buildModel(input int e);
        int a;
        int steps;
        int cyc;
        logic [CW+2:0] w;
        a = e;
        steps = 0;
        cyc = 2;
        expQ.delete();
        while (1) begin
            w = mem[a];
            expQ.push_back(w[CW-1:0]);
            steps++;
            if (w[CW+2] || steps == 64) break;
            cyc += 1 + int'(w[CW+1:CW]);
            a = (a + 1) % DEPTH;
        end
        expDoneRel = cyc + 1;
        expStep = (steps > 63) ? 63 : steps;
        expErr = w[CW+2] ? 0 : 1;
    endtask

    task automatic runInstr(input int e, input int maxHolds);
        int rel;
        int held;
        int idx;
        int holdsLeft;
        bit gotDone;
        buildModel(e);
        bus.i_start = 1'b1;
        bus.i_entryAddr = AW'(e);
        tick();
        bus.i_start = 1'b0;
        rel = 1;
        held = 0;
        idx = 0;
        gotDone = 0;
        holdsLeft = maxHolds;
        while (!gotDone && rel < 400) begin
            bus.i_hold = 1'b0;
            if (holdsLeft > 0 && $urandom_range(0, 3) == 0) begin
                bus.i_hold = 1'b1;
                holdsLeft--;
                held++;
            end
            @(negedge clk);
            if (rel == 1) begin
                chk("romAddrFetch", bus.o_romAddr, e);
                chk("busyFetch", bus.o_busy, 1);
                chk("errCleared", bus.o_err, 0);
            end
            if (rel == 2 && held == 0) begin
                chk("romAddrNext", bus.o_romAddr, (e + 1) % DEPTH);
            end
            if (bus.o_ctrlValid) begin
                if (idx < expQ.size()) chk("payload", bus.o_ctrl, expQ[idx]);
                else chk("extraStep", idx, expQ.size());
                idx++;
            end else begin
                chk("ctrlZero", bus.o_ctrl, 0);
            end
            if (bus.o_done) begin
                gotDone = 1;
                chk("doneCycle", rel, expDoneRel + held);
            end else begin
                tick();
                rel++;
            end
        end
        bus.i_hold = 1'b0;
        chk("doneSeen", gotDone, 1);
        chk("stepsIssued", idx, expQ.size());
        chk("oStep", bus.o_step, expStep);
        chk("oErr", bus.o_err, expErr);
        chk("busyAtDone", bus.o_busy, 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        bus.i_start = 1'b1;
        bus.i_entryAddr = 9'h040;
        bus.i_abort = 1'b0;
        bus.i_hold = 1'b0;
        nRst = 1'b0;
        tick();
        tick();
        bus.i_start = 1'b0;
        @(negedge clk);
        chk("rstRomAddr", bus.o_romAddr, 0);
        chk("rstRomEn", bus.o_romEn, 0);
        chk("rstValid", bus.o_ctrlValid, 0);
        chk("rstCtrl", bus.o_ctrl, 0);
        chk("rstBusy", bus.o_busy, 0);
        chk("rstDone", bus.o_done, 0);
        chk("rstStep", bus.o_step, 0);
        chk("rstErr", bus.o_err, 0);
        tick();
        nRst = 1'b1;
        tick();

        loadProg(32'h040, 3, 1, 0);
        runInstr(32'h040, 0);
        tick();

        mem[9'h041][CW+1:CW] = 2'd2;
        runInstr(32'h040, 0);
        tick();

        loadProg(32'h060, 5, 1, 1);
        runInstr(32'h060, 3);
        tick();

        loadProg(32'h080, 4, 1, 0);
        bus.i_start = 1'b1;
        bus.i_entryAddr = 9'h080;
        tick();
        bus.i_entryAddr = 9'h000;
        tick();
        bus.i_start = 1'b0;
        @(negedge clk);
        chk("busyStartIgnored", bus.o_ctrl, mem[9'h080][CW-1:0]);
        tick();
        bus.i_abort = 1'b1;
        @(negedge clk);
        chk("abortValid", bus.o_ctrlValid, 0);
        chk("abortRomEn", bus.o_romEn, 0);
        tick();
        bus.i_abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abortBusy", bus.o_busy, 0);
            chk("abortNoDone", bus.o_done, 0);
            tick();
        end
        bus.i_start = 1'b1;
        bus.i_abort = 1'b1;
        tick();
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        @(negedge clk);
        chk("startAbortIgnored", bus.o_busy, 0);
        tick();
        loadProg(32'h100, 3, 1, 1);
        runInstr(32'h100, 0);
        tick();

        loadProg(32'h1A0, 64, 0, 0);
        mem[(32'h1A0 + 64) % DEPTH] = '0;
        runInstr(32'h1A0, 0);
        tick();
        tick();
        @(negedge clk);
        chk("errSticky", bus.o_err, 1);
        tick();

        loadProg(32'h020, 2, 1, 0);
        loadProg(32'h1FF, 2, 1, 0);
        runInstr(32'h020, 0);
        runInstr(32'h1FF, 0);
        tick();

        loadProg(32'h0C0, 3, 1, 0);
        bus.i_start = 1'b1;
        bus.i_entryAddr = 9'h0C0;
        tick();
        bus.i_start = 1'b0;
        tick();
        tick();
        nRst = 1'b0;
        bus.i_start = 1'b1;
        tick();
        nRst = 1'b1;
        bus.i_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midRstBusy", bus.o_busy, 0);
            chk("midRstDone", bus.o_done, 0);
            chk("midRstValid", bus.o_ctrlValid, 0);
            tick();
        end
        chk("midRstStep", bus.o_step, 0);

        for (int k = 0; k < 8; k++) begin
            int e;
            int n;
            e = int'($urandom_range(0, DEPTH - 1));
            n = int'($urandom_range(1, 8));
            loadProg(e, n, 1, 1);
            runInstr(e, int'($urandom_range(0, 4)));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
